// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and load results in per-source FIFOs
// and broadcasts at most one per cycle, round-robin between the two sources.
module cdb_arbiter #(
    parameter int unsigned ROB_W = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             Clear_flag,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ROB_W-1:0] alu_tag,
    input  logic [31:0]      alu_value,
    input  logic             alu_jalr,
    input  logic [31:0]      alu_jumppc,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [ROB_W-1:0] lsu_tag,
    input  logic [31:0]      lsu_value,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_tag,
    output logic [31:0]      cdb_value,
    output logic             cdb_jalr,
    output logic [31:0]      cdb_jumppc,
    output logic             cdb_src,
    output logic             busy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    logic [ROB_W-1:0] alu_tag_mem [DEPTH];
    logic [31:0]      alu_val_mem [DEPTH];
    logic             alu_jalr_mem[DEPTH];
    logic [31:0]      alu_jpc_mem [DEPTH];
    logic [ROB_W-1:0] lsu_tag_mem [DEPTH];
    logic [31:0]      lsu_val_mem [DEPTH];

    logic [PTR_W-1:0] alu_wr, alu_rd, lsu_wr, lsu_rd;
    logic [CNT_W-1:0] alu_cnt, lsu_cnt;
    logic             last_grant;

    logic active, alu_push, lsu_push, alu_nempty, lsu_nempty;
    logic grant_alu, grant_lsu;

    // Handshake and round-robin grant; a full FIFO never accepts, even while popping.
    always_comb begin
        active     = rdy & ~Clear_flag;
        alu_nempty = (alu_cnt != '0);
        lsu_nempty = (lsu_cnt != '0);
        alu_ready  = active & (alu_cnt < CNT_W'(DEPTH));
        lsu_ready  = active & (lsu_cnt < CNT_W'(DEPTH));
        alu_push   = alu_valid & alu_ready;
        lsu_push   = lsu_valid & lsu_ready;
        grant_alu  = active & alu_nempty & (~lsu_nempty | (last_grant == SRC_LSU));
        grant_lsu  = active & lsu_nempty & ~grant_alu;
    end

    assign busy = alu_nempty | lsu_nempty | cdb_valid;

    // FIFO storage needs no reset; pointers and counts qualify its contents.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_tag_mem[alu_wr]  <= alu_tag;
            alu_val_mem[alu_wr]  <= alu_value;
            alu_jalr_mem[alu_wr] <= alu_jalr;
            alu_jpc_mem[alu_wr]  <= alu_jumppc;
        end
        if (lsu_push) begin
            lsu_tag_mem[lsu_wr] <= lsu_tag;
            lsu_val_mem[lsu_wr] <= lsu_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_wr     <= '0;
            alu_rd     <= '0;
            lsu_wr     <= '0;
            lsu_rd     <= '0;
            alu_cnt    <= '0;
            lsu_cnt    <= '0;
            last_grant <= SRC_LSU;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_value  <= '0;
            cdb_jalr   <= 1'b0;
            cdb_jumppc <= '0;
            cdb_src    <= SRC_ALU;
        end else if (rdy) begin
            if (Clear_flag) begin
                alu_wr     <= '0;
                alu_rd     <= '0;
                lsu_wr     <= '0;
                lsu_rd     <= '0;
                alu_cnt    <= '0;
                lsu_cnt    <= '0;
                last_grant <= SRC_LSU;
                cdb_valid  <= 1'b0;
            end else begin
                if (alu_push)  alu_wr <= alu_wr + PTR_W'(1);
                if (lsu_push)  lsu_wr <= lsu_wr + PTR_W'(1);
                if (grant_alu) alu_rd <= alu_rd + PTR_W'(1);
                if (grant_lsu) lsu_rd <= lsu_rd + PTR_W'(1);
                alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(grant_alu);
                lsu_cnt <= lsu_cnt + CNT_W'(lsu_push) - CNT_W'(grant_lsu);

                // Loads carry no jump target, so their broadcast clears it.
                if (grant_alu) begin
                    cdb_valid  <= 1'b1;
                    cdb_tag    <= alu_tag_mem[alu_rd];
                    cdb_value  <= alu_val_mem[alu_rd];
                    cdb_jalr   <= alu_jalr_mem[alu_rd];
                    cdb_jumppc <= alu_jpc_mem[alu_rd];
                    cdb_src    <= SRC_ALU;
                    last_grant <= SRC_ALU;
                end else if (grant_lsu) begin
                    cdb_valid  <= 1'b1;
                    cdb_tag    <= lsu_tag_mem[lsu_rd];
                    cdb_value  <= lsu_val_mem[lsu_rd];
                    cdb_jalr   <= 1'b0;
                    cdb_jumppc <= '0;
                    cdb_src    <= SRC_LSU;
                    last_grant <= SRC_LSU;
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes, hand-ordered expected broadcasts.
module tb_cdb_arbiter;
    typedef struct {
        logic [4:0]  tag;
        logic [31:0] val;
        logic        jalr;
        logic [31:0] jpc;
        logic        src;
    } item_t;

    logic        clk, rst, rdy, Clear_flag;
    logic        alu_valid, alu_ready, alu_jalr;
    logic [4:0]  alu_tag;
    logic [31:0] alu_value, alu_jumppc;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_tag;
    logic [31:0] lsu_value;
    logic        cdb_valid, cdb_jalr, cdb_src, busy;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value, cdb_jumppc;

    int    n_checks = 0;
    int    n_pass   = 0;
    item_t exp_q[$];
    item_t aq[$];
    item_t lq[$];
    logic  fresh = 1'b0;
    logic  saw_stall;

    cdb_arbiter #(.ROB_W(5), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(Clear_flag),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tag(alu_tag),
        .alu_value(alu_value), .alu_jalr(alu_jalr), .alu_jumppc(alu_jumppc),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_tag(lsu_tag),
        .lsu_value(lsu_value), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_jalr(cdb_jalr), .cdb_jumppc(cdb_jumppc),
        .cdb_src(cdb_src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic item_t mk(input logic [4:0] t, input logic [31:0] v,
                                 input logic j, input logic [31:0] p, input logic s);
        item_t it;
        it.tag = t; it.val = v; it.jalr = j; it.jpc = p; it.src = s;
        return it;
    endfunction

    // A broadcast is new only after an edge where the block was allowed to advance.
    always @(posedge clk) fresh = rdy && !Clear_flag && rst;

    always @(negedge clk) begin
        if (fresh && cdb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_broadcast", {1'b1, cdb_tag, cdb_value}, 80'd0);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                chk("broadcast", {cdb_tag, cdb_value, cdb_jalr, cdb_jumppc, cdb_src},
                    {e.tag, e.val, e.jalr, e.jpc, e.src});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; lsu_valid = 0; alu_jalr = 0;
        alu_tag = 0; alu_value = 0; alu_jumppc = 0; lsu_tag = 0; lsu_value = 0;
    endtask

    task automatic clear_pulse();
        idle_inputs();
        Clear_flag = 1;
        step();
        Clear_flag = 0;
    endtask

    // Drives aq/lq with valid/ready handshakes; rdy low for two iterations at frz_at.
    task automatic pump(input int frz_at, input logic [31:0] frz_val);
        int  i = 0;
        logic a_acc, l_acc;
        while ((aq.size() > 0 || lq.size() > 0) && i < 200) begin
            rdy = !(frz_at >= 0 && (i == frz_at || i == frz_at + 1));
            alu_valid = aq.size() > 0;
            if (alu_valid) begin
                alu_tag = aq[0].tag; alu_value = aq[0].val;
                alu_jalr = aq[0].jalr; alu_jumppc = aq[0].jpc;
            end
            lsu_valid = lq.size() > 0;
            if (lsu_valid) begin
                lsu_tag = lq[0].tag; lsu_value = lq[0].val;
            end
            #1;
            if (rdy && !alu_ready) saw_stall = 1;
            a_acc = alu_valid && alu_ready;
            l_acc = lsu_valid && lsu_ready;
            step();
            if (a_acc) void'(aq.pop_front());
            if (l_acc) void'(lq.pop_front());
            if (!rdy) chk("frozen_output", {cdb_valid, cdb_value}, {1'b1, frz_val});
            i++;
        end
        if (i >= 200) chk("pump_timeout", 80'(i), 80'd0);
        rdy = 1;
        idle_inputs();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        chk(name, 80'(exp_q.size()), 80'd0);
    endtask

    initial begin
        rst = 0; rdy = 1; Clear_flag = 0; saw_stall = 0;
        idle_inputs();
        #1;
        chk("reset_cdb", {cdb_valid, cdb_tag, cdb_value, cdb_jalr, cdb_jumppc, cdb_src}, 80'd0);
        chk("reset_busy", 80'(busy), 80'd0);
        #11 rst = 1;
        step();
        chk("ready_after_reset", {alu_ready, lsu_ready}, 80'b11);

        // Single ALU result: two-edge latency, one-cycle valid.
        exp_q.push_back(mk(5'd3, 32'h11, 1'b0, 32'h0, 1'b0));
        alu_valid = 1; alu_tag = 5'd3; alu_value = 32'h11;
        step();
        idle_inputs();
        chk("busy_buffered", 80'(busy), 80'd1);
        step();
        step();
        chk("single_valid_drop", {cdb_valid, cdb_tag, busy}, {1'b0, 5'd3, 1'b0});
        drain("single_drained");

        // Equal contention alternates ALU, LSU.
        clear_pulse();
        for (int k = 0; k < 3; k++) begin
            aq.push_back(mk(5'd1, 32'hA0 + 32'(k), 1'b0, 32'h0, 1'b0));
            lq.push_back(mk(5'd2, 32'hB0 + 32'(k), 1'b0, 32'h0, 1'b1));
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(aq[k]);
            exp_q.push_back(lq[k]);
        end
        pump(-1, 32'h0);
        drain("rr_drained");

        // ALU backpressure while the LSU keeps the bus busy.
        clear_pulse();
        saw_stall = 0;
        for (int k = 0; k < 3; k++) aq.push_back(mk(5'(8 + k), 32'h80 + 32'(k), 1'b0, 32'h0, 1'b0));
        for (int k = 0; k < 4; k++) lq.push_back(mk(5'(12 + k), 32'hC0 + 32'(k), 1'b0, 32'h0, 1'b1));
        exp_q.push_back(aq[0]); exp_q.push_back(lq[0]);
        exp_q.push_back(aq[1]); exp_q.push_back(lq[1]);
        exp_q.push_back(aq[2]); exp_q.push_back(lq[2]);
        exp_q.push_back(lq[3]);
        pump(-1, 32'h0);
        chk("alu_ready_dropped", 80'(saw_stall), 80'd1);
        drain("backpressure_drained");

        // JALR target broadcast, then a load clears it.
        clear_pulse();
        aq.push_back(mk(5'd5, 32'h55, 1'b1, 32'h1000, 1'b0));
        lq.push_back(mk(5'd7, 32'h77, 1'b0, 32'h0, 1'b1));
        exp_q.push_back(aq[0]); exp_q.push_back(lq[0]);
        pump(-1, 32'h0);
        drain("jalr_drained");

        // Flush with entries buffered in both FIFOs.
        clear_pulse();
        exp_q.push_back(mk(5'd3, 32'h31, 1'b0, 32'h0, 1'b0));
        alu_valid = 1; alu_tag = 5'd3; alu_value = 32'h31;
        lsu_valid = 1; lsu_tag = 5'd4; lsu_value = 32'h41;
        step();
        alu_value = 32'h32; lsu_value = 32'h42;
        step();
        Clear_flag = 1;
        #1;
        chk("ready_low_in_flush", {alu_ready, lsu_ready}, 80'b00);
        step();
        Clear_flag = 0;
        idle_inputs();
        #1;
        chk("after_flush", {cdb_valid, busy, alu_ready, lsu_ready}, 80'b0011);
        repeat (3) step();
        drain("flush_drained");

        // rdy low for two cycles mid-stream freezes everything.
        clear_pulse();
        for (int k = 0; k < 3; k++) begin
            aq.push_back(mk(5'd1, 32'hD0 + 32'(k), 1'b0, 32'h0, 1'b0));
            lq.push_back(mk(5'd2, 32'hE0 + 32'(k), 1'b0, 32'h0, 1'b1));
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(aq[k]);
            exp_q.push_back(lq[k]);
        end
        pump(3, 32'hE0);
        drain("freeze_drained");

        // Asynchronous reset with entries buffered.
        clear_pulse();
        exp_q.push_back(mk(5'd9, 32'h99, 1'b1, 32'h2000, 1'b0));
        alu_valid = 1; alu_tag = 5'd9; alu_value = 32'h99; alu_jalr = 1; alu_jumppc = 32'h2000;
        lsu_valid = 1; lsu_tag = 5'd10; lsu_value = 32'hAA;
        step();
        idle_inputs();
        step();
        #6 rst = 0;
        #1;
        chk("async_reset_cdb", {cdb_valid, cdb_tag, cdb_value, cdb_jalr, cdb_jumppc, cdb_src}, 80'd0);
        chk("async_reset_busy", 80'(busy), 80'd0);
        #4 rst = 1;
        step();
        chk("ready_after_async_reset", {alu_ready, lsu_ready, busy}, 80'b110);
        repeat (4) step();
        chk("reset_discarded", {cdb_valid, busy}, 80'b00);
        drain("final_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
